// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter in front of an SRAM controller
// Every output is registered; the combinational process computes next values only.
module sram_arbiter #(
   parameter int TIMEOUT_CYC = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p1_req,
   input  logic        p0_we,
   input  logic        p1_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p0_wdata,
   input  logic [31:0] p1_wdata,
   output logic        p0_gnt,
   output logic        p1_gnt,
   output logic        p0_done,
   output logic        p1_done,
   output logic        err,
   output logic [63:0] rdata,
   output logic        m_rd_en,
   output logic        m_wr_en,
   output logic [31:0] m_address,
   output logic [31:0] m_write_data,
   input  logic [63:0] m_read_data,
   input  logic        m_ready
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        r_state, w_state;
   logic          r_ptr, w_ptr;
   logic          r_win, w_win;
   logic          r_we, w_we;
   logic [CW-1:0] r_cnt, w_cnt;
   logic          r_p0_gnt, w_p0_gnt, r_p1_gnt, w_p1_gnt;
   logic          r_p0_done, w_p0_done, r_p1_done, w_p1_done;
   logic          r_err, w_err;
   logic [63:0]   r_rdata, w_rdata;
   logic          r_rd_en, w_rd_en, r_wr_en, w_wr_en;
   logic [31:0]   r_addr, w_addr, r_wdata, w_wdata;
   logic          w_sel;
   logic [CW-1:0] w_cnt_inc;

   // The pointer only matters when both ports contend.
   assign w_sel     = (p0_req & p1_req) ? r_ptr : p1_req;
   assign w_cnt_inc = r_cnt + CW'(1);

   always_comb begin
      w_state   = r_state;
      w_ptr     = r_ptr;
      w_win     = r_win;
      w_we      = r_we;
      w_cnt     = r_cnt;
      w_p0_gnt  = 1'b0;
      w_p1_gnt  = 1'b0;
      w_p0_done = 1'b0;
      w_p1_done = 1'b0;
      w_err     = 1'b0;
      w_rdata   = r_rdata;
      w_rd_en   = r_rd_en;
      w_wr_en   = r_wr_en;
      w_addr    = r_addr;
      w_wdata   = r_wdata;
      case (r_state)
         IDLE: begin
            if (p0_req | p1_req) begin
               w_win    = w_sel;
               w_we     = w_sel ? p1_we : p0_we;
               w_addr   = w_sel ? p1_addr : p0_addr;
               w_wdata  = w_sel ? p1_wdata : p0_wdata;
               w_rd_en  = ~w_we;
               w_wr_en  = w_we;
               w_cnt    = '0;
               w_p0_gnt = ~w_sel;
               w_p1_gnt = w_sel;
               w_state  = BUSY;
            end
         end
         BUSY: begin
            // A ready in the final allowed cycle still beats the timeout.
            if (m_ready || (w_cnt_inc == CW'(TIMEOUT_CYC))) begin
               if (m_ready && !r_we) begin
                  w_rdata = m_read_data;
               end
               w_err     = ~m_ready;
               w_rd_en   = 1'b0;
               w_wr_en   = 1'b0;
               w_p0_done = ~r_win;
               w_p1_done = r_win;
               w_ptr     = ~r_win;
               w_state   = RESP;
            end
            w_cnt = w_cnt_inc;
         end
         RESP: begin
            w_state = IDLE;
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_ptr     <= 1'b0;
         r_win     <= 1'b0;
         r_we      <= 1'b0;
         r_cnt     <= '0;
         r_p0_gnt  <= 1'b0;
         r_p1_gnt  <= 1'b0;
         r_p0_done <= 1'b0;
         r_p1_done <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
         r_rd_en   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         r_state   <= w_state;
         r_ptr     <= w_ptr;
         r_win     <= w_win;
         r_we      <= w_we;
         r_cnt     <= w_cnt;
         r_p0_gnt  <= w_p0_gnt;
         r_p1_gnt  <= w_p1_gnt;
         r_p0_done <= w_p0_done;
         r_p1_done <= w_p1_done;
         r_err     <= w_err;
         r_rdata   <= w_rdata;
         r_rd_en   <= w_rd_en;
         r_wr_en   <= w_wr_en;
         r_addr    <= w_addr;
         r_wdata   <= w_wdata;
      end
   end

   assign p0_gnt       = r_p0_gnt;
   assign p1_gnt       = r_p1_gnt;
   assign p0_done      = r_p0_done;
   assign p1_done      = r_p1_done;
   assign err          = r_err;
   assign rdata        = r_rdata;
   assign m_rd_en      = r_rd_en;
   assign m_wr_en      = r_wr_en;
   assign m_address    = r_addr;
   assign m_write_data = r_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
// Transaction-level reference: winner from a round-robin pointer, err from latency vs timeout.
module tb_sram_arbiter;

   localparam int TO = 31;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p1_req, p0_we, p1_we;
   logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic        p0_gnt, p1_gnt, p0_done, p1_done, err;
   logic [63:0] rdata;
   logic        m_rd_en, m_wr_en;
   logic [31:0] m_address, m_write_data;
   logic [63:0] m_read_data;
   logic        m_ready;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [63:0] exp_rdata;
   logic        mptr;

   typedef struct {
      logic        r0, r1, we0, we1;
      logic [31:0] a0, a1, d0, d1;
      int          lat;
      logic [63:0] rd;
      logic        ew;
   } vec_t;

   vec_t tbl [8];

   sram_arbiter #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
      .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
      .err(err), .rdata(rdata), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
      .m_address(m_address), .m_write_data(m_write_data),
      .m_read_data(m_read_data), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
      p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
      m_read_data = 0; m_ready = 0;
      step();
      step();
      rst = 1'b1;
      exp_rdata = 0;
      mptr = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_ctl"}, 64'({p0_gnt, p1_gnt, p0_done, p1_done, err, m_rd_en, m_wr_en}), 64'd0);
      chk({name, "_addr"}, 64'({m_address, m_write_data}), 64'd0);
      chk({name, "_rdata"}, rdata, 64'd0);
   endtask

   task automatic run_txn(input logic r0, input logic r1, input logic we0, input logic we1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input int lat, input logic [63:0] rd, input logic ew);
      int          k;
      logic        we_w, bad, exp_err;
      logic [31:0] a_w, d_w;
      int          exp_k;
      p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
      k = 0;
      do begin
         step();
         k++;
      end while (!(p0_gnt | p1_gnt) && k < 20);
      chk("gnt_latency", 64'(k), 64'd1);
      p0_req = 0;
      p1_req = 0;
      we_w = ew ? we1 : we0;
      a_w  = ew ? a1 : a0;
      d_w  = ew ? d1 : d0;
      chk("gnt_port", 64'({p1_gnt, p0_gnt}), ew ? 64'd2 : 64'd1);
      chk("m_address", 64'(m_address), 64'(a_w));
      chk("m_write_data", 64'(m_write_data), 64'(d_w));
      exp_err = (lat > TO);
      exp_k   = exp_err ? TO + 1 : lat + 1;
      bad = 0;
      k = 1;
      m_read_data = rd;
      m_ready = (lat == 1);
      while (!(p0_done | p1_done) && k < 100) begin
         if (m_rd_en !== ~we_w || m_wr_en !== we_w || p0_gnt !== 1'b0 && k > 1) bad = 1;
         step();
         k++;
         m_ready = (k == lat);
      end
      m_ready = 0;
      chk("enables_busy", 64'(bad), 64'd0);
      chk("done_cycle", 64'(k), 64'(exp_k));
      chk("done_port", 64'({p1_done, p0_done}), ew ? 64'd2 : 64'd1);
      chk("err", 64'(err), 64'(exp_err));
      if (!exp_err && !we_w) exp_rdata = rd;
      chk("rdata", rdata, exp_rdata);
      chk("enables_resp", 64'({m_rd_en, m_wr_en}), 64'd0);
      step();
      chk("done_clear", 64'({p1_done, p0_done, err}), 64'd0);
   endtask

   initial begin
      int          ng, k, c, done_c, g1_c;
      logic        bad;
      logic        wins [4];
      logic [1:0]  r;
      logic        ew;

      tbl[0] = '{1, 0, 0, 0, 32'h400, 0, 0, 0, 6, 64'h1122334455667788, 0};
      tbl[1] = '{0, 1, 0, 1, 0, 32'h408, 0, 32'hDEADBEEF, 3, 64'hAAAAAAAAAAAAAAAA, 1};
      tbl[2] = '{1, 1, 0, 0, 32'h10, 32'h20, 0, 0, 1, 64'h0102030405060708, 0};
      tbl[3] = '{1, 1, 0, 0, 32'h14, 32'h24, 0, 0, 31, 64'h5555666677778888, 1};
      tbl[4] = '{1, 0, 0, 0, 32'h40, 0, 0, 0, 40, 64'h9999999999999999, 0};
      tbl[5] = '{0, 1, 0, 0, 0, 32'h44, 0, 0, 2, 64'h7777000077770000, 1};
      tbl[6] = '{0, 1, 0, 0, 0, 32'h48, 0, 0, 32, 64'h3333333333333333, 1};
      tbl[7] = '{1, 1, 1, 0, 32'h30, 32'h34, 32'h12345678, 0, 4, 64'hCCCCCCCCCCCCCCCC, 0};

      // reset state, sampled while reset is still asserted
      rst = 1'b0;
      p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
      p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
      m_read_data = 0; m_ready = 0;
      step();
      step();
      chk_reset_outputs("reset_state");
      do_reset();

      foreach (tbl[i]) begin
         run_txn(tbl[i].r0, tbl[i].r1, tbl[i].we0, tbl[i].we1, tbl[i].a0, tbl[i].a1,
                 tbl[i].d0, tbl[i].d1, tbl[i].lat, tbl[i].rd, tbl[i].ew);
      end

      // m_ready asserted while idle must not produce a completion
      m_ready = 1;
      bad = 0;
      repeat (4) begin
         step();
         if (p0_done | p1_done | p0_gnt | p1_gnt) bad = 1;
      end
      m_ready = 0;
      chk("ready_ignored_idle", 64'(bad), 64'd0);

      // continuous contention from reset: grants alternate
      do_reset();
      p0_req = 1; p1_req = 1; p0_addr = 32'h100; p1_addr = 32'h200;
      ng = 0; k = 0; bad = 0;
      for (int i = 0; i < 200 && ng < 4; i++) begin
         step();
         if ((m_rd_en & m_wr_en) | (p0_gnt & p1_gnt)) bad = 1;
         if (p0_gnt | p1_gnt) begin
            wins[ng] = p1_gnt;
            ng++;
            k = 1;
         end else if (k > 0) begin
            k++;
         end
         if (p0_done | p1_done) k = 0;
         m_ready = (k == 2);
      end
      p0_req = 0; p1_req = 0; m_ready = 0;
      chk("contention_grants", 64'(ng), 64'd4);
      chk("contention_order", 64'({wins[0], wins[1], wins[2], wins[3]}), 64'b0101);
      chk("contention_overlap", 64'(bad), 64'd0);

      // reset during BUSY cycle 3 abandons the transaction
      do_reset();
      p0_req = 1; p0_addr = 32'h500;
      step();
      chk("mid_gnt", 64'(p0_gnt), 64'd1);
      p0_req = 0;
      step();
      step();
      rst = 1'b0;
      step();
      chk_reset_outputs("mid_reset");
      rst = 1'b1;
      bad = 0;
      repeat (5) begin
         step();
         if (p0_done | p1_done | m_rd_en | m_wr_en) bad = 1;
      end
      chk("mid_no_done", 64'(bad), 64'd0);
      exp_rdata = 0;
      run_txn(0, 1, 0, 0, 0, 32'h600, 0, 0, 3, 64'h0A0B0C0D0E0F1011, 1);

      // p1 raised during p0's BUSY waits for the following IDLE
      p0_req = 1; p0_we = 0; p0_addr = 32'h700;
      p1_we = 0; p1_addr = 32'h704;
      c = 0; k = 0; done_c = -1; g1_c = -1;
      for (int i = 0; i < 60 && g1_c < 0; i++) begin
         step();
         c++;
         if (p0_gnt) begin
            p0_req = 0;
            k = 1;
         end else if (k > 0) begin
            k++;
         end
         if (k == 2) p1_req = 1;
         if (p0_done && done_c < 0) begin
            done_c = c;
            k = 0;
         end
         if (p1_gnt) begin
            g1_c = c;
            p1_req = 0;
         end
         m_ready = (k == 5);
      end
      m_ready = 0;
      chk("late_done_cycle", 64'(done_c), 64'd6);
      chk("late_gnt_cycle", 64'(g1_c), 64'(done_c + 2));

      // randomized traffic against the transaction-level model
      do_reset();
      for (int i = 0; i < 30; i++) begin
         r  = 2'($urandom_range(1, 3));
         ew = (r[0] & r[1]) ? mptr : r[1];
         run_txn(r[0], r[1], 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                 $urandom_range(1, 36), {$urandom, $urandom}, ew);
         mptr = ~ew;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 31: maximum cycles waited for m_ready before aborting a transaction.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
REQ-004 SHALL have ports p0_req, p1_req  input  1 each  requester holds high until granted.
REQ-005 SHALL have ports p0_we, p1_we  input  1 each  1 = write, 0 = read; valid with req.
REQ-006 SHALL have ports p0_addr, p1_addr  input  32 each  byte address; valid with req.
REQ-007 SHALL have ports p0_wdata, p1_wdata  input  32 each  write word; valid with req.
REQ-008 SHALL have ports p0_gnt, p1_gnt  output  1 each  one-cycle pulse: request accepted.
REQ-009 SHALL have ports p0_done, p1_done  output  1 each  one-cycle pulse: transaction finished.
REQ-010 SHALL have port err  output  1  qualifies done: 1 = transaction aborted by timeout.
REQ-011 SHALL have port rdata  output  64  read result; valid in the done cycle and held until the next done.
REQ-012 SHALL have ports m_rd_en, m_wr_en  output  1 each  read/write enables to the SRAM controller.
REQ-013 SHALL have ports m_address, m_write_data  output  32 each  address/data to the SRAM controller.
REQ-014 SHALL have ports m_read_data  input  64 and m_ready  input  1  controller result and completion flag.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP; all outputs registered.
REQ-016 IDLE: if any req is high, SHALL select a winner, latch its we/addr/wdata into m_* registers, pulse its gnt, and enter BUSY next cycle; otherwise stay IDLE.
REQ-017 Arbitration SHALL be round-robin via a 1-bit priority pointer (reset 0 = port 0 first); on a simultaneous request, the port named by the pointer wins.
REQ-018 Pointer SHALL toggle to the non-winner when a transaction completes (done or timeout); with a single requester the pointer is irrelevant and that port wins.
REQ-019 BUSY: SHALL hold m_rd_en = ~we or m_wr_en = we (never both), with address/data stable, for the entire state.
REQ-020 BUSY: the first cycle m_ready = 1 SHALL capture m_read_data into rdata (reads only; writes leave rdata unchanged), drop both enables, and enter RESP.
REQ-021 m_ready SHALL be ignored in IDLE and RESP.
REQ-022 RESP: SHALL pulse the winner's done with err = 0, then return to IDLE; minimum gnt-to-gnt spacing is therefore 3 cycles plus controller latency.
REQ-023 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle; if it reaches TIMEOUT_CYC with no m_ready, SHALL drop enables, enter RESP, and pulse done with err = 1, leaving rdata unchanged.
REQ-024 gnt SHALL never assert outside IDLE; a req rising during BUSY/RESP SHALL wait and be arbitrated in the next IDLE.
REQ-025 A requester deasserting req before gnt SHALL be treated as withdrawn with no side effects.
REQ-026 The width of the wait counter SHALL be sized to hold TIMEOUT_CYC without wrap-around.

Reset
REQ-027 While rst = 0 at a clock edge: state = IDLE, pointer = 0, counter = 0, rdata = 0, all gnt/done/err/m_rd_en/m_wr_en = 0, m_address = m_write_data = 0.
REQ-028 Reset during BUSY SHALL abandon the transaction without a done pulse; enables low the cycle after the reset edge.

Verification
REQ-029 Single read: p0 read at addr 0x400, controller model returns 0x1122334455667788 after 6 cycles -> p0_gnt one pulse, m_rd_en high exactly through BUSY, p0_done with err = 0, rdata = 0x1122334455667788.
REQ-030 Contention: p0 and p1 requesting simultaneously, continuously, from reset -> grants alternate p0, p1, p0, p1; no overlapping enables.
REQ-031 Write: p1 writes 0xDEADBEEF to 0x408 -> m_wr_en high with m_address = 0x408, m_write_data = 0xDEADBEEF; p1_done pulses; rdata unchanged.
REQ-032 Timeout: m_ready held at 0 -> done with err = 1 exactly TIMEOUT_CYC cycles after BUSY entry; enables drop; next request is served normally.
REQ-033 Reset mid-transaction: rst = 0 during BUSY cycle 3 -> no done pulse; all outputs at their reset values; a subsequent p1-only request is granted to p1.
REQ-034 Late request: p1_req raised during p0's BUSY -> p1_gnt only in the IDLE cycle after p0_done, never earlier.
